// File: rtl/icache_cg_pkg.sv
// Shared types and sizing helpers for the icache clock-gate controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package icache_cg_pkg;

    // Encoding matches the state_o debug output.
    typedef enum logic [1:0] {
        CG_OFF  = 2'd0,
        CG_WAKE = 2'd1,
        CG_ON   = 2'd2,
        CG_HOLD = 2'd3
    } cg_state_e;

    // Width of the statistics counter.
    localparam int STATS_W = 32;

    // Width of the settle/hysteresis counter.
    // It is sized for the larger of the two loads and is never narrower than 1 bit.
    function automatic int CG_CNT_W(input int wake_cycles, input int hyst_cycles);
        int m;
        m = (wake_cycles > hyst_cycles) ? wake_cycles : hyst_cycles;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/icache_clock_gate_ctrl_if.sv
// Bundles the request and grant signals between the icache clients and the gate controller.
// Latency: n/a (wires only).
// Backpressure: a request is held until ready is returned.
interface icache_clock_gate_ctrl_if #(
    parameter int NREQ = 4
);
    import icache_cg_pkg::*;

    logic [NREQ-1:0]    req;
    logic               force_on;
    logic               stats_clr;
    logic [NREQ-1:0]    ready;
    logic               gate_en;
    logic [1:0]         state_o;
    logic [STATS_W-1:0] gated_cycles;

    // Client side: drives requests and the overrides, and sees grants.
    modport master (
        output req, force_on, stats_clr,
        input  ready, gate_en, state_o, gated_cycles
    );

    // Controller side.
    modport slave (
        input  req, force_on, stats_clr,
        output ready, gate_en, state_o, gated_cycles
    );

endinterface

// File: rtl/icache_cg_sat_counter.sv
// Saturating event counter. A clear takes priority over an increment.
// Latency: the count reflects inc/clr one cycle after they are sampled.
// Backpressure: none; the count sticks at all-ones instead of wrapping.
module icache_cg_sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Clear first, then increment while below all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/icache_clock_gate_ctrl.sv
// Icache clock-gate enable controller: OFF -> WAKE -> ON -> HOLD, with hysteresis before gating off.
// Latency: ready rises WAKE_CYCLES+1 cycles after a request seen in OFF, and 1 cycle after a request seen in HOLD.
// Backpressure: requests are level signals held until ready; grants are shared, not exclusive.
// Optional macro ICACHE_CLOCK_GATE_STATS_EN adds the gated_cycles counter, which counts cycles spent in OFF.
module icache_clock_gate_ctrl
    import icache_cg_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int HYST_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    icache_clock_gate_ctrl_if.slave bus
);

    localparam int CW = CG_CNT_W(WAKE_CYCLES, HYST_CYCLES);
    localparam logic [CW-1:0] WAKE_LD = CW'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] HYST_LD = CW'((HYST_CYCLES > 0) ? HYST_CYCLES - 1 : 0);

    cg_state_e         state;
    logic [CW-1:0]     cnt;
    logic              gate_en_q;
    logic              any;

    assign any = (|bus.req) | bus.force_on;

    // State, counter and gate enable all update together.
    // gate_en has its own flop, so it cannot glitch when several state bits change at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= CG_OFF;
            cnt       <= '0;
            gate_en_q <= 1'b0;
        end else begin
            case (state)
                CG_OFF: begin
                    if (any) begin
                        gate_en_q <= 1'b1;
                        if (WAKE_CYCLES == 0) begin
                            state <= CG_ON;
                            cnt   <= '0;
                        end else begin
                            state <= CG_WAKE;
                            cnt   <= WAKE_LD;
                        end
                    end
                end
                CG_WAKE: begin
                    // A request that drops here does not abort the wake; ON then falls through to HOLD.
                    if (cnt == '0) begin
                        state <= CG_ON;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                CG_ON: begin
                    if (!any) begin
                        if (HYST_CYCLES == 0) begin
                            state     <= CG_OFF;
                            cnt       <= '0;
                            gate_en_q <= 1'b0;
                        end else begin
                            state <= CG_HOLD;
                            cnt   <= HYST_LD;
                        end
                    end
                end
                CG_HOLD: begin
                    // The clock is still running, so a request returns to ON with no wake delay.
                    // This check comes first, so a request wins when the counter reaches zero.
                    if (any) begin
                        state <= CG_ON;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state     <= CG_OFF;
                        cnt       <= '0;
                        gate_en_q <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state     <= CG_OFF;
                    cnt       <= '0;
                    gate_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gate_en = gate_en_q;
    assign bus.state_o = state;
    assign bus.ready   = bus.req & {NREQ{state == CG_ON}};

`ifdef ICACHE_CLOCK_GATE_STATS_EN
    icache_cg_sat_counter #(
        .W (STATS_W)
    ) u_stats (
        .clock (clock),
        .reset (reset),
        .clr   (bus.stats_clr),
        .inc   (state == CG_OFF),
        .cnt   (bus.gated_cycles)
    );
`else
    logic unused_stats_clr;
    assign unused_stats_clr = bus.stats_clr;
    assign bus.gated_cycles = '0;
`endif

endmodule

// File: tb/tb_icache_clock_gate_ctrl.sv
// Directed bench for icache_clock_gate_ctrl with NREQ=4, WAKE_CYCLES=2 and HYST_CYCLES=4.
// Inputs change 1 time unit after each rising edge, and outputs are sampled at that point.
module tb_icache_clock_gate_ctrl;
    import icache_cg_pkg::*;

    logic clock;
    logic reset;
    int   total;
    int   passed;

    icache_clock_gate_ctrl_if #(.NREQ(4)) cg_if ();

    icache_clock_gate_ctrl #(
        .NREQ        (4),
        .WAKE_CYCLES (2),
        .HYST_CYCLES (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (cg_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        cg_if.req       = 4'b0000;
        cg_if.force_on  = 1'b0;
        cg_if.stats_clr = 1'b0;
        tick();
        tick();
        chk("rst_state",   32'(cg_if.state_o), 32'd0);
        chk("rst_gate_en", 32'(cg_if.gate_en), 32'd0);
        chk("rst_ready",   32'(cg_if.ready),   32'd0);
        chk("rst_gated",   cg_if.gated_cycles, 32'd0);
        reset = 1'b0;

        // Statistics: clear, then let the controller sit idle in OFF for 100 cycles.
        cg_if.stats_clr = 1'b1;
        tick();
        cg_if.stats_clr = 1'b0;
        for (int i = 0; i < 100; i++) tick();
`ifdef ICACHE_CLOCK_GATE_STATS_EN
        chk("gated_100", cg_if.gated_cycles, 32'd100);
`else
        chk("gated_100", cg_if.gated_cycles, 32'd0);
`endif
        cg_if.stats_clr = 1'b1;
        tick();
        cg_if.stats_clr = 1'b0;
        chk("gated_clr", cg_if.gated_cycles, 32'd0);
        tick();
`ifdef ICACHE_CLOCK_GATE_STATS_EN
        chk("gated_after_clr", cg_if.gated_cycles, 32'd1);
`else
        chk("gated_after_clr", cg_if.gated_cycles, 32'd0);
`endif

        // Wake from OFF: WAKE for two cycles, then ON with the grant.
        cg_if.req = 4'b0001;
        #1;
        chk("off_ready", 32'(cg_if.ready), 32'd0);
        tick();
        chk("wake1_state",   32'(cg_if.state_o), 32'd1);
        chk("wake1_gate_en", 32'(cg_if.gate_en), 32'd1);
        chk("wake1_ready",   32'(cg_if.ready),   32'd0);
        tick();
        chk("wake2_state", 32'(cg_if.state_o), 32'd1);
        chk("wake2_ready", 32'(cg_if.ready),   32'd0);
        tick();
        chk("on_state", 32'(cg_if.state_o), 32'd2);
        chk("on_ready", 32'(cg_if.ready),   32'd1);
        tick();
        tick();
        chk("on_hold_ready", 32'(cg_if.ready), 32'd1);

        // Drop the request: still ON this cycle, then four cycles of HOLD, then OFF.
        cg_if.req = 4'b0000;
        #1;
        chk("drop_ready", 32'(cg_if.ready),   32'd0);
        chk("drop_state", 32'(cg_if.state_o), 32'd2);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("hyst%0d_state", i), 32'(cg_if.state_o), 32'd3);
            chk($sformatf("hyst%0d_gate", i),  32'(cg_if.gate_en), 32'd1);
        end
        tick();
        chk("gateoff_state", 32'(cg_if.state_o), 32'd0);
        chk("gateoff_gate",  32'(cg_if.gate_en), 32'd0);

        // Get back to ON, drop the request, then re-request during HOLD: ON next cycle, with no WAKE.
        cg_if.req = 4'b0001;
        tick(); tick(); tick();
        chk("on2_state", 32'(cg_if.state_o), 32'd2);
        cg_if.req = 4'b0000;
        tick();
        tick();
        chk("h2_state", 32'(cg_if.state_o), 32'd3);
        cg_if.req = 4'b0100;
        #1;
        chk("hold_ready0", 32'(cg_if.ready), 32'd0);
        tick();
        chk("rehit_state", 32'(cg_if.state_o), 32'd2);
        chk("rehit_ready", 32'(cg_if.ready),   32'd4);

        // The HOLD counter reaches zero in the same cycle req[1] rises: the request wins.
        cg_if.req = 4'b0000;
        tick();
        tick(); tick(); tick();
        chk("h_last_state", 32'(cg_if.state_o), 32'd3);
        cg_if.req = 4'b0010;
        tick();
        chk("race_state", 32'(cg_if.state_o), 32'd2);
        chk("race_gate",  32'(cg_if.gate_en), 32'd1);
        chk("race_ready", 32'(cg_if.ready),   32'd2);

        // Return to OFF, then use force_on alone.
        cg_if.req = 4'b0000;
        for (int i = 0; i < 5; i++) tick();
        chk("off2_state", 32'(cg_if.state_o), 32'd0);
        cg_if.force_on = 1'b1;
        tick();
        chk("f_wake_gate", 32'(cg_if.gate_en), 32'd1);
        tick(); tick();
        chk("f_on_state", 32'(cg_if.state_o), 32'd2);
        chk("f_on_ready", 32'(cg_if.ready),   32'd0);
        chk("f_on_gate",  32'(cg_if.gate_en), 32'd1);
        tick();
        chk("f_stay_state", 32'(cg_if.state_o), 32'd2);
        cg_if.force_on = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("f_hold_state", 32'(cg_if.state_o), 32'd3);
        tick();
        chk("f_off_state", 32'(cg_if.state_o), 32'd0);
        chk("f_off_gate",  32'(cg_if.gate_en), 32'd0);

        // Assert reset asynchronously in WAKE: the gate closes at once.
        cg_if.req = 4'b0001;
        tick();
        chk("pre_rst_state", 32'(cg_if.state_o), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_gate",  32'(cg_if.gate_en), 32'd0);
        chk("arst_state", 32'(cg_if.state_o), 32'd0);
        chk("arst_ready", 32'(cg_if.ready),   32'd0);
        tick();
        cg_if.req = 4'b0000;
        reset = 1'b0;
        tick();
        chk("post_rst_state", 32'(cg_if.state_o), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
